// File: rtl/vga_capture.sv
// vga_capture: receive side of the on-board VGA stream.
// Registers the incoming RGB/sync/blank signals and locks to the start of a frame.
// Quantises each active pixel to {R,G,B} bits and writes it into a 3-bit-per-pixel frame buffer.
// Also checks the geometry of the received frame and reports errors.
module vga_capture #(
    parameter int         H_DISP = 800,
    parameter int         V_DISP = 600,
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_vga_r,
    input  logic [7:0]  i_vga_g,
    input  logic [7:0]  i_vga_b,
    input  logic        i_vga_hs,
    input  logic        i_vga_vs,
    input  logic        i_vga_blank_n,
    input  logic        i_capture_en,
    input  logic        i_continuous,
    input  logic        i_abort,
    output logic        o_wr_en,
    output logic [18:0] o_wr_addr,
    output logic [2:0]  o_wr_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [2:0]  o_err_code,
    output logic [9:0]  o_line_cnt
);

    localparam logic [18:0] ADDR_MAX = 19'(H_DISP * V_DISP);
    localparam logic [10:0] H_LEN    = 11'(H_DISP);
    localparam logic [9:0]  V_LEN    = 10'(V_DISP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Per-channel threshold: a channel at or above THRESH becomes a 1.
    function automatic logic [2:0] quantise(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {(r >= THRESH), (g >= THRESH), (b >= THRESH)};
    endfunction

    // Input stage and delayed copies for edge detection.
    logic [7:0]  r_s1_r, r_s1_g, r_s1_b;
    logic        r_s1_hs, r_s1_vs, r_s1_blank_n;
    logic        r_vs_d, r_blank_d;

    state_t      r_state;
    logic [18:0] r_addr;
    logic [10:0] r_pix_cnt;
    logic [9:0]  r_lines;
    logic        r_wr_en, r_busy, r_frame_done;
    logic [18:0] r_wr_addr;
    logic [2:0]  r_wr_data;
    logic [2:0]  r_err;
    logic [9:0]  r_line_out;

    logic        w_vs_rise, w_vs_fall, w_blank_fall, w_addr_full;
    logic [9:0]  w_lines_next;

    assign w_vs_rise    = r_s1_vs & ~r_vs_d;
    assign w_vs_fall    = ~r_s1_vs & r_vs_d;
    assign w_blank_fall = ~r_s1_blank_n & r_blank_d;
    assign w_addr_full  = (r_addr == ADDR_MAX);

    // Line count including a line that ends in this very cycle (saturating).
    always_comb begin
        w_lines_next = r_lines;
        if (w_blank_fall && (r_lines != 10'h3FF)) begin
            w_lines_next = r_lines + 10'd1;
        end else begin
            w_lines_next = r_lines;
        end
    end

    // Register every video input once and keep the previous sync/blank values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_r       <= 8'd0;
            r_s1_g       <= 8'd0;
            r_s1_b       <= 8'd0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_blank_n <= 1'b0;
            r_vs_d       <= 1'b0;
            r_blank_d    <= 1'b0;
        end else begin
            r_s1_r       <= i_vga_r;
            r_s1_g       <= i_vga_g;
            r_s1_b       <= i_vga_b;
            r_s1_hs      <= i_vga_hs;
            r_s1_vs      <= i_vga_vs;
            r_s1_blank_n <= i_vga_blank_n;
            r_vs_d       <= r_s1_vs;
            r_blank_d    <= r_s1_blank_n;
        end
    end

    // Capture FSM: frame lock, pixel writes, geometry checks and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= 19'd0;
            r_pix_cnt    <= 11'd0;
            r_lines      <= 10'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 19'd0;
            r_wr_data    <= 3'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 3'd0;
            r_line_out   <= 10'd0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_capture_en) begin
                            r_state <= ST_WAIT_VS;
                            r_busy  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_WAIT_VS: begin
                        r_busy <= 1'b1;
                        if (w_vs_rise) begin
                            r_state   <= ST_CAPTURE;
                            r_addr    <= 19'd0;
                            r_pix_cnt <= 11'd0;
                            r_lines   <= 10'd0;
                            r_err     <= 3'd0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_s1_blank_n) begin
                            if (w_addr_full) begin
                                // Buffer full: drop the pixel, keep the address pinned.
                                r_err[2] <= 1'b1;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_addr;
                                r_wr_data <= quantise(r_s1_r, r_s1_g, r_s1_b);
                                r_addr    <= r_addr + 19'd1;
                            end
                            if (r_pix_cnt != 11'h7FF) begin
                                r_pix_cnt <= r_pix_cnt + 11'd1;
                            end
                        end
                        if (w_blank_fall) begin
                            r_pix_cnt <= 11'd0;
                            r_lines   <= w_lines_next;
                            if (r_pix_cnt != H_LEN) begin
                                r_err[0] <= 1'b1;
                            end
                        end
                        if (w_vs_fall) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_line_out   <= w_lines_next;
                            if (w_lines_next != V_LEN) begin
                                r_err[1] <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // The sync that ended the frame cannot start the next one:
                        // re-arm and wait for its rising edge.
                        if (i_continuous) begin
                            r_state <= ST_WAIT_VS;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_err_code   = r_err;
    assign o_line_cnt   = r_line_out;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized frames on a reduced 16x8 geometry, checked against a
// pixel-list reference model and frame-level expectations.
module tb_vga_capture;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int MAXA = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_vga_r, i_vga_g, i_vga_b;
    logic        i_vga_hs, i_vga_vs, i_vga_blank_n;
    logic        i_capture_en, i_continuous, i_abort;
    logic        o_wr_en;
    logic [18:0] o_wr_addr;
    logic [2:0]  o_wr_data;
    logic        o_busy, o_frame_done;
    logic [2:0]  o_err_code;
    logic [9:0]  o_line_cnt;

    vga_capture #(.H_DISP(H), .V_DISP(V), .THRESH(8'd128)) dut (
        .clk(clk), .rst(rst),
        .i_vga_r(i_vga_r), .i_vga_g(i_vga_g), .i_vga_b(i_vga_b),
        .i_vga_hs(i_vga_hs), .i_vga_vs(i_vga_vs), .i_vga_blank_n(i_vga_blank_n),
        .i_capture_en(i_capture_en), .i_continuous(i_continuous), .i_abort(i_abort),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_err_code(o_err_code), .o_line_cnt(o_line_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Compare one observed value with its expectation.
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the ordered list of writes the frame buffer must receive.
    int exp_q[$];
    int wr_cnt = 0, done_cnt = 0, last_addr = -1, first_data = -1, zero_cnt = 0;
    int mon_e;

    function automatic int qm(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return ((r >= 8'd128) ? 4 : 0) + ((g >= 8'd128) ? 2 : 0) + ((b >= 8'd128) ? 1 : 0);
    endfunction

    // Observe the write port and frame-done strobe between clock edges.
    always @(negedge clk) begin
        if (o_wr_en) begin
            wr_cnt++;
            last_addr = int'(o_wr_addr);
            if (o_wr_addr == 19'd0) begin
                zero_cnt++;
                first_data = int'(o_wr_data);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(o_wr_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", int'(o_wr_addr), mon_e / 8);
                check("wr_data", int'(o_wr_data), mon_e % 8);
            end
        end
        if (o_frame_done) done_cnt++;
    end

    task automatic cyc(input logic vs, input logic hs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        i_vga_vs = vs; i_vga_hs = hs; i_vga_blank_n = bl;
        i_vga_r = r; i_vga_g = g; i_vga_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(4);
    endtask

    task automatic pulse_cap();
        i_capture_en = 1'b1;
        idle(1);
        i_capture_en = 1'b0;
    endtask

    // One frame: sync pulse, then nlines lines; cap says whether the DUT should record it.
    task automatic send_frame(input bit cap, input int nlines, input int short_line,
                              input int short_len, input bit fixed_first,
                              input int cap_line, input int rst_line);
        int a;
        int len;
        bit capping;
        logic [7:0] r, g, b;
        a = 0;
        capping = cap;
        vs_pulse();
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? short_len : H;
            for (int p = 0; p < len; p++) begin
                r = 8'($urandom_range(255));
                g = 8'($urandom_range(255));
                b = 8'($urandom_range(255));
                if (fixed_first && l == 0 && p == 0) begin
                    r = 8'd127; g = 8'd128; b = 8'd255;
                end
                i_capture_en = (l == cap_line && p == 0);
                if (capping) begin
                    if (a < MAXA) exp_q.push_back(a * 8 + qm(r, g, b));
                    a++;
                end
                cyc(1'b1, 1'b1, 1'b1, r, g, b);
            end
            i_capture_en = 1'b0;
            for (int q = 0; q < 6; q++) begin
                if (l == rst_line && q == 2) begin
                    rst = 1'b1;
                    idle(1);
                    rst = 1'b0;
                    check("rst_wr_en", int'(o_wr_en), 0);
                    check("rst_busy", int'(o_busy), 0);
                    capping = 1'b0;
                end else begin
                    cyc(1'b1, (q == 2 || q == 3) ? 1'b0 : 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
                end
            end
        end
        idle(2);
    endtask

    // Single-shot capture of one frame followed by frame-level checks.
    task automatic one_shot(input string tag, input int nlines, input int short_line,
                            input int short_len, input bit fixed_first,
                            input int exp_wr, input int exp_err);
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        pulse_cap();
        check({tag, "_busy_armed"}, int'(o_busy), 1);
        send_frame(1'b1, nlines, short_line, short_len, fixed_first, -1, -1);
        vs_pulse();
        idle(3);
        check({tag, "_writes"}, wr_cnt - w0, exp_wr);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, int'(o_err_code), exp_err);
        check({tag, "_line_cnt"}, int'(o_line_cnt), nlines);
        check({tag, "_last_addr"}, last_addr, exp_wr - 1);
        check({tag, "_queue"}, exp_q.size(), 0);
        check({tag, "_busy_end"}, int'(o_busy), 0);
    endtask

    initial begin
        int w0, d0, z0;
        rst = 1'b1; i_capture_en = 1'b0; i_continuous = 1'b0; i_abort = 1'b0;
        idle(3);
        check("reset_wr_en", int'(o_wr_en), 0);
        check("reset_wr_addr", int'(o_wr_addr), 0);
        check("reset_wr_data", int'(o_wr_data), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_frame_done", int'(o_frame_done), 0);
        check("reset_err", int'(o_err_code), 0);
        check("reset_line_cnt", int'(o_line_cnt), 0);
        rst = 1'b0;
        idle(4);

        one_shot("std", V, -1, 0, 1'b0, MAXA, 0);
        one_shot("short_line", V, 3, H - 1, 1'b0, MAXA - 1, 1);
        one_shot("few_lines", V - 1, -1, 0, 1'b0, MAXA - H, 2);
        one_shot("extra_line", V + 1, -1, 0, 1'b0, MAXA, 6);
        one_shot("quant", V, -1, 0, 1'b1, MAXA, 0);
        check("quant_first_data", first_data, 3);

        // Arming in the middle of a frame: nothing until the next sync rising edge.
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b0, V, -1, 0, 1'b0, 2, -1);
        check("midcap_writes", wr_cnt - w0, 0);
        check("midcap_busy", int'(o_busy), 1);
        send_frame(1'b1, V, -1, 0, 1'b0, -1, -1);
        vs_pulse();
        idle(3);
        check("midcap_next_writes", wr_cnt - w0, MAXA);
        check("midcap_done", done_cnt - d0, 1);
        check("midcap_queue", exp_q.size(), 0);

        // Reset in the middle of a capture discards the rest of the frame.
        d0 = done_cnt;
        pulse_cap();
        send_frame(1'b1, V, -1, 0, 1'b0, -1, 3);
        vs_pulse();
        idle(3);
        check("rst_mid_done", done_cnt - d0, 0);
        check("rst_mid_queue", exp_q.size(), 0);
        check("rst_mid_err", int'(o_err_code), 0);
        check("rst_mid_line_cnt", int'(o_line_cnt), 0);

        // Abort and arm in the same cycle: abort wins.
        w0 = wr_cnt; d0 = done_cnt;
        i_abort = 1'b1; i_capture_en = 1'b1;
        idle(1);
        i_abort = 1'b0; i_capture_en = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        send_frame(1'b0, V, -1, 0, 1'b0, -1, -1);
        vs_pulse();
        idle(3);
        check("abort_writes", wr_cnt - w0, 0);
        check("abort_done", done_cnt - d0, 0);

        // Continuous mode over three frames.
        w0 = wr_cnt; d0 = done_cnt; z0 = zero_cnt;
        i_continuous = 1'b1;
        pulse_cap();
        for (int f = 0; f < 3; f++) send_frame(1'b1, V, -1, 0, 1'b0, -1, -1);
        i_continuous = 1'b0;
        vs_pulse();
        idle(3);
        check("cont_done", done_cnt - d0, 3);
        check("cont_addr0", zero_cnt - z0, 3);
        check("cont_writes", wr_cnt - w0, 3 * MAXA);
        check("cont_queue", exp_q.size(), 0);
        check("cont_err", int'(o_err_code), 0);
        check("cont_line_cnt", int'(o_line_cnt), V);
        check("cont_busy", int'(o_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
